// File: rtl/srm_mem_pkg.sv
// Shared types and constants for the SRM-Starter memory bus sequencer.
package srm_mem_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR
  } mem_seq_state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  function automatic logic [AW-1:0] word_align(input logic [AW-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/srm_lane_merge.sv
// Big-endian sub-word lane merge: replaces the addressed byte/half of a word.
module srm_lane_merge
  import srm_mem_pkg::*;
(
  input  logic [DW-1:0] old_word,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    size,
  input  logic [1:0]    off,
  output logic [DW-1:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    merged[31:24] = wdata[7:0];
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) merged[15:0]  = wdata[15:0];
        else        merged[31:16] = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/srm_mem_sequencer.sv
// Single-port bus sequencer: fetch/data arbitration, RMW for sub-word stores,
// and a per-transaction ack watchdog.
module srm_mem_sequencer
  import srm_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  mem_seq_state_t state, state_n;
  grant_t         last_grant, last_n;
  grant_t         owner_q, owner_n;
  logic [1:0]     size_q, size_n;
  logic [1:0]     off_q, off_n;
  logic [DW-1:0]  wdata_q, dwdata_n;
  logic [TW-1:0]  wd, wd_n;
  logic           fail_q, fail_n;
  logic           req_n, we_n;
  logic [AW-1:0]  addr_n;
  logic [DW-1:0]  wdata_n;
  logic [DW-1:0]  merged;
  logic           ack;
  logic           bus_done;

  srm_lane_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .size     (size_q),
    .off      (off_q),
    .merged   (merged)
  );

  // Read data is a straight pass-through, qualified by the acks.
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Next-state, registered-output and ack logic.
  always_comb begin
    state_n  = state;
    last_n   = last_grant;
    owner_n  = owner_q;
    size_n   = size_q;
    off_n    = off_q;
    dwdata_n = wdata_q;
    wd_n     = wd;
    fail_n   = 1'b0;
    req_n    = mem_req;
    we_n     = mem_we;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    ack      = 1'b0;
    err      = 1'b0;
    bus_done = mem_req && mem_ack;

    if (mem_req && !mem_ack) wd_n = wd + TW'(1);

    case (state)
      IDLE: begin
        if (d_req && (!if_req || last_grant == GNT_FETCH)) begin
          last_n   = GNT_DATA;
          owner_n  = GNT_DATA;
          size_n   = d_size;
          off_n    = d_addr[1:0];
          dwdata_n = d_wdata;
          addr_n   = word_align(d_addr);
          wd_n     = '0;
          if (d_size == SZ_RSVD) begin
            // Reserved size: no bus cycle, error ack on the next cycle.
            fail_n  = 1'b1;
            state_n = LOAD;
          end else begin
            req_n   = 1'b1;
            we_n    = d_we && (d_size == SZ_WORD);
            wdata_n = d_wdata;
            if (!d_we)                 state_n = LOAD;
            else if (d_size == SZ_WORD) state_n = STORE;
            else                        state_n = RMW_RD;
          end
        end else if (if_req) begin
          last_n  = GNT_FETCH;
          owner_n = GNT_FETCH;
          addr_n  = word_align(if_addr);
          wd_n    = '0;
          req_n   = 1'b1;
          we_n    = 1'b0;
          state_n = FETCH;
        end
      end
      FETCH, LOAD, STORE: begin
        if (fail_q) begin
          ack     = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (bus_done) begin
          ack     = 1'b1;
          req_n   = 1'b0;
          we_n    = 1'b0;
          state_n = IDLE;
        end
      end
      RMW_RD: begin
        if (fail_q) begin
          ack     = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (bus_done) begin
          req_n   = 1'b0;
          wdata_n = merged;
          state_n = RMW_WR;
        end
      end
      RMW_WR: begin
        if (fail_q) begin
          ack     = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (!mem_req) begin
          req_n = 1'b1;
          we_n  = 1'b1;
          wd_n  = '0;
        end else if (bus_done) begin
          ack     = 1'b1;
          req_n   = 1'b0;
          we_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Watchdog expiry abandons the outstanding bus cycle.
    if (TIMEOUT != 0 && mem_req && !mem_ack && wd == TW'(TIMEOUT - 1)) begin
      req_n  = 1'b0;
      we_n   = 1'b0;
      fail_n = 1'b1;
    end

    if_ack = ack && (owner_q == GNT_FETCH);
    d_ack  = ack && (owner_q == GNT_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_FETCH;
      owner_q    <= GNT_FETCH;
      size_q     <= SZ_WORD;
      off_q      <= 2'd0;
      wdata_q    <= '0;
      wd         <= '0;
      fail_q     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
      owner_q    <= owner_n;
      size_q     <= size_n;
      off_q      <= off_n;
      wdata_q    <= dwdata_n;
      wd         <= wd_n;
      fail_q     <= fail_n;
      mem_req    <= req_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
    end
  end

endmodule
